// File: rtl/instr_fetch_unit_if.sv
// Handshake bundle between the fetch unit, instruction memory and the CPU core.
// The master modport is the fetch unit; the slave modport is its environment.
interface instr_fetch_unit_if;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_gnt;
  logic        imem_rvalid;
  logic [31:0] imem_rdata;
  logic        instr_valid;
  logic        instr_ready;
  logic [31:0] instr_data;
  logic [31:0] instr_pc;
  logic        redirect_valid;
  logic [31:0] redirect_pc;

  modport master (
    output imem_req, imem_addr, instr_valid, instr_data, instr_pc,
    input  imem_gnt, imem_rvalid, imem_rdata, instr_ready, redirect_valid, redirect_pc
  );

  modport slave (
    input  imem_req, imem_addr, instr_valid, instr_data, instr_pc,
    output imem_gnt, imem_rvalid, imem_rdata, instr_ready, redirect_valid, redirect_pc
  );
endinterface

// File: rtl/instr_fetch_unit.sv
// Instruction fetch unit: one outstanding word read to imem, small output FIFO
// toward the core, and PC redirect with flush of buffered and in-flight words.
module instr_fetch_unit #(
  parameter logic [31:0] RESET_PC   = 32'h0000_0000,
  parameter int          FIFO_DEPTH = 2
) (
  input  logic               clk,
  input  logic               rst_n,
  instr_fetch_unit_if.master bus
);

  localparam int PTR_W = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int CNT_W = $clog2(FIFO_DEPTH + 1);

  typedef enum logic [1:0] {IDLE, REQ, WAIT} state_e;

  state_e             state_q, state_d;
  logic [31:0]        fetch_pc_q, fetch_pc_d;
  logic [31:0]        req_pc_q, req_pc_d;
  logic               drop_q, drop_d;
  logic [PTR_W-1:0]   rd_ptr_q, rd_ptr_d;
  logic [PTR_W-1:0]   wr_ptr_q, wr_ptr_d;
  logic [CNT_W-1:0]   count_q, count_d;
  logic [31:0]        pc_mem_q   [FIFO_DEPTH];
  logic [31:0]        data_mem_q [FIFO_DEPTH];

  logic               redirect;
  logic [31:0]        target_pc;
  logic               push;
  logic               pop;

  function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
    return (p == PTR_W'(FIFO_DEPTH - 1)) ? '0 : p + 1'b1;
  endfunction

  assign redirect  = bus.redirect_valid;
  assign target_pc = bus.redirect_pc & ~32'd3;
  assign pop       = (count_q != '0) && bus.instr_ready;

  always_comb begin
    state_d    = state_q;
    fetch_pc_d = fetch_pc_q;
    req_pc_d   = req_pc_q;
    drop_d     = drop_q;
    push       = 1'b0;

    case (state_q)
      IDLE: begin
        if (redirect || (count_q < CNT_W'(FIFO_DEPTH)))
          state_d = REQ;
      end
      REQ: begin
        if (bus.imem_gnt) begin
          req_pc_d   = fetch_pc_q;
          fetch_pc_d = fetch_pc_q + 32'd4;
          state_d    = WAIT;
          // A redirect racing the grant leaves a response in flight that must be discarded.
          if (redirect)
            drop_d = 1'b1;
        end
      end
      WAIT: begin
        if (bus.imem_rvalid) begin
          push   = !drop_q && !redirect;
          drop_d = 1'b0;
          if (redirect ||
              ((count_q + CNT_W'(push) - CNT_W'(pop)) < CNT_W'(FIFO_DEPTH)))
            state_d = REQ;
          else
            state_d = IDLE;
        end else if (redirect) begin
          drop_d = 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase

    if (redirect)
      fetch_pc_d = target_pc;
  end

  // FIFO bookkeeping; a redirect empties the buffer after any same-cycle pop.
  always_comb begin
    rd_ptr_d = rd_ptr_q;
    wr_ptr_d = wr_ptr_q;
    count_d  = count_q + CNT_W'(push) - CNT_W'(pop);
    if (pop)
      rd_ptr_d = ptr_inc(rd_ptr_q);
    if (push)
      wr_ptr_d = ptr_inc(wr_ptr_q);
    if (redirect) begin
      rd_ptr_d = '0;
      wr_ptr_d = '0;
      count_d  = '0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= IDLE;
      fetch_pc_q <= RESET_PC;
      req_pc_q   <= RESET_PC;
      drop_q     <= 1'b0;
      rd_ptr_q   <= '0;
      wr_ptr_q   <= '0;
      count_q    <= '0;
      for (int i = 0; i < FIFO_DEPTH; i++) begin
        pc_mem_q[i]   <= '0;
        data_mem_q[i] <= '0;
      end
    end else begin
      state_q    <= state_d;
      fetch_pc_q <= fetch_pc_d;
      req_pc_q   <= req_pc_d;
      drop_q     <= drop_d;
      rd_ptr_q   <= rd_ptr_d;
      wr_ptr_q   <= wr_ptr_d;
      count_q    <= count_d;
      if (push) begin
        pc_mem_q[wr_ptr_q]   <= req_pc_q;
        data_mem_q[wr_ptr_q] <= bus.imem_rdata;
      end
    end
  end

  assign bus.imem_req    = (state_q == REQ);
  assign bus.imem_addr   = fetch_pc_q;
  assign bus.instr_valid = (count_q != '0);
  assign bus.instr_data  = data_mem_q[rd_ptr_q];
  assign bus.instr_pc    = pc_mem_q[rd_ptr_q];

endmodule

// File: tb/tb_instr_fetch_unit.sv
// Randomized bench for instr_fetch_unit: memory responder, core/redirect driver,
// and a scoreboard monitor that expects a sequential word stream restarted at each redirect.
module tb_instr_fetch_unit;
  localparam logic [31:0] RST_PC = 32'hFFFF_FFF8;

  logic clk = 1'b0;
  logic rst_n = 1'b0;

  instr_fetch_unit_if bus ();

  instr_fetch_unit #(.RESET_PC(RST_PC), .FIFO_DEPTH(2)) dut (
    .clk  (clk),
    .rst_n(rst_n),
    .bus  (bus)
  );

  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;
  logic [31:0] exp_q[$];
  logic [31:0] gen_pc = RST_PC;
  int acc_cnt = 0;
  int gnt_cnt = 0;
  int gnt_pct = 100;
  int dly_min = 1;
  int dly_max = 1;

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return (a * 32'h9E37_79B1) ^ 32'h1357_9BDF;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got %08h want %08h at %0t", name, act, req, $time);
    end
  endtask

  // Memory responder: random grant, response 1..N cycles after grant.
  bit          pend = 0;
  int          pend_cnt = 0;
  logic [31:0] pend_addr;
  bit          prev_req_nognt = 0;
  bit          prev_redir = 0;
  logic [31:0] prev_addr;

  always @(negedge clk) begin
    #2;
    if (!rst_n) begin
      pend            = 0;
      prev_req_nognt  = 0;
      bus.imem_gnt    = 1'b0;
      bus.imem_rvalid = 1'b0;
      bus.imem_rdata  = '0;
    end else begin
      if (prev_req_nognt && !prev_redir) begin
        chk("req_held", bus.imem_req, 1);
        chk("addr_held", bus.imem_addr, prev_addr);
      end
      bus.imem_rvalid = 1'b0;
      bus.imem_rdata  = $urandom;
      if (pend) begin
        pend_cnt--;
        if (pend_cnt == 0) begin
          pend            = 0;
          bus.imem_rvalid = 1'b1;
          bus.imem_rdata  = mem_word(pend_addr);
        end
      end
      bus.imem_gnt = 1'b0;
      if (bus.imem_req) begin
        chk("addr_align", bus.imem_addr & 32'd3, 0);
        chk("one_outstanding", pend, 0);
        if ($urandom_range(1, 100) <= gnt_pct) begin
          bus.imem_gnt = 1'b1;
          gnt_cnt++;
          pend      = 1;
          pend_cnt  = $urandom_range(dly_min, dly_max);
          pend_addr = bus.imem_addr;
        end
      end
      prev_req_nognt = bus.imem_req && !bus.imem_gnt;
      prev_addr      = bus.imem_addr;
      prev_redir     = bus.redirect_valid;
    end
  end

  // Monitor: pops the scoreboard on each core handshake, checks hold stability.
  bit          hold_prev = 0;
  logic [31:0] hold_pc, hold_data, mon_e;

  always @(negedge clk) begin
    #1;
    if (!rst_n) begin
      hold_prev = 0;
    end else begin
      if (hold_prev) begin
        chk("hold_valid", bus.instr_valid, 1);
        chk("hold_pc", bus.instr_pc, hold_pc);
        chk("hold_data", bus.instr_data, hold_data);
      end
      if (bus.instr_valid && bus.instr_ready) begin
        acc_cnt++;
        if (exp_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL sb_empty: got pc %08h want none", bus.instr_pc);
        end else begin
          mon_e = exp_q.pop_front();
          chk("instr_pc", bus.instr_pc, mon_e);
          chk("instr_data", bus.instr_data, mem_word(mon_e));
        end
      end
      hold_prev = bus.instr_valid && !bus.instr_ready && !bus.redirect_valid;
      hold_pc   = bus.instr_pc;
      hold_data = bus.instr_data;
    end
  end

  task automatic refill();
    while (exp_q.size() < 16) begin
      exp_q.push_back(gen_pc);
      gen_pc += 32'd4;
    end
  endtask

  task automatic step(input bit rdy, input bit rv, input logic [31:0] tgt);
    @(negedge clk);
    refill();
    bus.instr_ready    = rdy;
    bus.redirect_valid = rv;
    bus.redirect_pc    = tgt;
    @(posedge clk);
    #1;
    if (rv) begin
      exp_q.delete();
      gen_pc = tgt & ~32'd3;
      chk("flush_valid", bus.instr_valid, 0);
    end
  endtask

  task automatic check_reset_outputs(input string tag);
    chk({tag, "_req"}, bus.imem_req, 0);
    chk({tag, "_addr"}, bus.imem_addr, RST_PC);
    chk({tag, "_valid"}, bus.instr_valid, 0);
    chk({tag, "_data"}, bus.instr_data, 0);
    chk({tag, "_pc"}, bus.instr_pc, 0);
  endtask

  task automatic random_steps(input int n, input bit allow_redirect);
    logic [31:0] tgt;
    bit rv;
    for (int i = 0; i < n; i++) begin
      rv  = allow_redirect && ($urandom_range(0, 19) == 0);
      tgt = ($urandom_range(0, 1) == 0) ? $urandom : ($urandom_range(0, 255) | 32'hFFFF_FF00);
      step($urandom_range(0, 3) != 0, rv, tgt);
    end
  endtask

  int a0, g0;
  bit found;

  initial begin
    bus.instr_ready    = 1'b0;
    bus.redirect_valid = 1'b0;
    bus.redirect_pc    = '0;
    repeat (3) @(negedge clk);
    #1;
    check_reset_outputs("rst");

    @(negedge clk);
    #3;
    rst_n = 1'b1;
    #1;
    chk("first_req_pre", bus.imem_req, 0);
    @(posedge clk);
    #1;
    chk("first_req", bus.imem_req, 1);
    chk("first_addr", bus.imem_addr, RST_PC);

    // Full-speed streaming across the address wrap: one word every two cycles.
    gnt_pct = 100; dly_min = 1; dly_max = 1;
    repeat (6) step(1, 0, 0);
    a0 = acc_cnt;
    repeat (40) step(1, 0, 0);
    chk("throughput", acc_cnt - a0, 20);

    // Backpressure: buffer fills, fetching stops, head holds.
    repeat (15) step(0, 0, 0);
    chk("bp_req", bus.imem_req, 0);
    chk("bp_valid", bus.instr_valid, 1);
    g0 = gnt_cnt;
    repeat (8) step(0, 0, 0);
    chk("bp_no_gnt", gnt_cnt - g0, 0);
    chk("bp_req_still", bus.imem_req, 0);
    gnt_pct = 0;
    a0 = acc_cnt;
    repeat (6) step(1, 0, 0);
    chk("bp_depth", acc_cnt - a0, 2);
    chk("stall_req", bus.imem_req, 1);
    gnt_pct = 100;
    repeat (10) step(1, 0, 0);

    // Random grants, latencies, core stalls and redirects.
    gnt_pct = 60; dly_min = 1; dly_max = 3;
    a0 = acc_cnt;
    random_steps(2500, 1);
    checks++;
    if (acc_cnt - a0 < 100) begin
      errors++;
      $display("FAIL progress: got %0d accepts want >=100", acc_cnt - a0);
    end

    // Reset while a response is outstanding.
    found = 0;
    dly_min = 2; dly_max = 3;
    for (int i = 0; i < 50 && !found; i++) begin
      step($urandom_range(0, 1), 0, 0);
      if (pend) found = 1;
    end
    checks++;
    if (!found) begin
      errors++;
      $display("FAIL wait_timeout: got no outstanding fetch want one within 50 cycles");
    end
    @(negedge clk);
    #3;
    rst_n = 1'b0;
    bus.instr_ready    = 1'b0;
    bus.redirect_valid = 1'b0;
    #1;
    check_reset_outputs("midrst");
    exp_q.delete();
    gen_pc = RST_PC;
    @(negedge clk);
    #3;
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    chk("refetch_addr", bus.imem_addr, RST_PC);
    a0 = acc_cnt;
    random_steps(400, 1);
    checks++;
    if (acc_cnt - a0 < 10) begin
      errors++;
      $display("FAIL progress_after_reset: got %0d accepts want >=10", acc_cnt - a0);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
